// File: rtl/crc_frame_checker.sv
// Receive-side CRC checker: folds payload beats through a parallel Galois LFSR
// and compares the result against the trailing CRC beat, one result record per frame.
module crc_frame_checker #(
    parameter int unsigned       D_WIDTH = 16,
    parameter int unsigned       WIDTH   = 16,
    parameter logic [WIDTH-1:0]  POLY    = 16'h6801,
    parameter logic [WIDTH-1:0]  INIT    = 16'h0000,
    parameter int unsigned       LEN_W   = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [D_WIDTH-1:0] in_data,
    input  logic               in_last,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               res_ok,
    output logic               res_runt,
    output logic [LEN_W-1:0]   res_beats,
    output logic [WIDTH-1:0]   res_crc,
    output logic [15:0]        err_cnt
);

    typedef enum logic [1:0] {IDLE, BODY, RESULT} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   lfsr_q, lfsr_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               ok_q, ok_d;
    logic               runt_q, runt_d;
    logic [15:0]        err_q, err_d;

    // D_WIDTH serial MSB-first Galois steps unrolled into one cycle.
    function automatic logic [WIDTH-1:0] fold(input logic [WIDTH-1:0] s,
                                              input logic [D_WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        r = s;
        for (int i = D_WIDTH - 1; i >= 0; i--) begin
            r = {r[WIDTH-2:0], d[i]} ^ (r[WIDTH-1] ? POLY : '0);
        end
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = in_last ? RESULT : BODY;
            BODY:    if (in_valid && in_last) state_d = RESULT;
            RESULT:  if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q != RESULT);
        res_valid = (state_q == RESULT);
    end

    always_comb begin
        lfsr_d = lfsr_q;
        cnt_d  = cnt_q;
        ok_d   = ok_q;
        runt_d = runt_q;
        err_d  = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_last) begin
                        runt_d = 1'b1;
                        ok_d   = 1'b0;
                        cnt_d  = '0;
                        lfsr_d = INIT;
                    end else begin
                        lfsr_d = fold(INIT, in_data);
                        cnt_d  = LEN_W'(1);
                    end
                end
            end
            BODY: begin
                if (in_valid) begin
                    if (in_last) begin
                        // The CRC beat is compared, never folded.
                        ok_d   = (lfsr_q == in_data[WIDTH-1:0]);
                        runt_d = 1'b0;
                    end else begin
                        lfsr_d = fold(lfsr_q, in_data);
                        if (cnt_q != '1) cnt_d = cnt_q + LEN_W'(1);
                    end
                end
            end
            RESULT: begin
                if (res_ready) begin
                    lfsr_d = INIT;
                    cnt_d  = '0;
                    if (!ok_q && err_q != 16'hFFFF) err_d = err_q + 16'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= INIT;
            cnt_q  <= '0;
            ok_q   <= 1'b0;
            runt_q <= 1'b0;
            err_q  <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            cnt_q  <= cnt_d;
            ok_q   <= ok_d;
            runt_q <= runt_d;
            err_q  <= err_d;
        end
    end

    assign res_ok    = ok_q;
    assign res_runt  = runt_q;
    assign res_beats = cnt_q;
    assign res_crc   = lfsr_q;
    assign err_cnt   = err_q;

endmodule

// File: tb/tb_crc_frame_checker.sv
// Directed bench for crc_frame_checker: default instance plus a LEN_W=2 instance
// sharing the same stimulus to exercise beat-count saturation.
module tb_crc_frame_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_last;
    logic        res_ready;

    logic        in_ready, res_valid, res_ok, res_runt;
    logic [11:0] res_beats;
    logic [15:0] res_crc, err_cnt;

    logic        s_in_ready, s_res_valid, s_res_ok, s_res_runt;
    logic [1:0]  s_res_beats;
    logic [15:0] s_res_crc, s_err_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    crc_frame_checker u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .res_valid(res_valid), .res_ready(res_ready), .res_ok(res_ok), .res_runt(res_runt),
        .res_beats(res_beats), .res_crc(res_crc), .err_cnt(err_cnt)
    );

    crc_frame_checker #(.LEN_W(2)) u_small (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .in_last(in_last),
        .res_valid(s_res_valid), .res_ready(res_ready), .res_ok(s_res_ok), .res_runt(s_res_runt),
        .res_beats(s_res_beats), .res_crc(s_res_crc), .err_cnt(s_err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present a beat from the falling edge and hold it until accepted.
    task automatic send(input logic [15:0] d, input logic l);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic handshake();
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    task automatic check_res(input string tag, input logic ok, input logic runt,
                             input logic [11:0] beats, input logic [15:0] crc);
        chk({tag, "_valid"}, 32'(res_valid), 32'd1);
        chk({tag, "_ok"},    32'(res_ok),    32'(ok));
        chk({tag, "_runt"},  32'(res_runt),  32'(runt));
        chk({tag, "_beats"}, 32'(res_beats), 32'(beats));
        chk({tag, "_crc"},   32'(res_crc),   32'(crc));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_ok", 32'(res_ok), 32'd0);
        chk("rst_res_beats", 32'(res_beats), 32'd0);
        chk("rst_res_crc", 32'(res_crc), 32'h0000);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);

        // {0x0001, CRC 0x0001}: result visible right after the last beat's edge
        send(16'h0001, 1'b0);
        send(16'h0001, 1'b1);
        check_res("f1", 1'b1, 1'b0, 12'd1, 16'h0001);
        chk("f1_in_ready", 32'(in_ready), 32'd0);
        handshake();
        chk("f1_err", 32'(err_cnt), 32'd0);
        chk("f1_valid_drop", 32'(res_valid), 32'd0);

        send(16'h0001, 1'b0); send(16'h0000, 1'b0); send(16'h6801, 1'b1);
        check_res("f2", 1'b1, 1'b0, 12'd2, 16'h6801);
        handshake();
        chk("f2_err", 32'(err_cnt), 32'd0);

        send(16'h0001, 1'b0); send(16'h0000, 1'b0); send(16'h6800, 1'b1);
        check_res("f3", 1'b0, 1'b0, 12'd2, 16'h6801);
        handshake();
        chk("f3_err", 32'(err_cnt), 32'd1);

        send(16'hABCD, 1'b1);
        check_res("runt", 1'b0, 1'b1, 12'd0, 16'h0000);
        handshake();
        chk("runt_err", 32'(err_cnt), 32'd2);

        // Backpressure with a pending beat held on the input during the stall
        send(16'h0001, 1'b0); send(16'h0001, 1'b1);
        @(negedge clk);
        in_valid = 1'b1; in_data = 16'h0001; in_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(res_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_crc", 32'(res_crc), 32'h0001);
            chk("bp_beats", 32'(res_beats), 32'd1);
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        chk("bp_idle_ready", 32'(in_ready), 32'd1);
        chk("bp_idle_valid", 32'(res_valid), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        send(16'h0001, 1'b1);
        check_res("bp_next", 1'b1, 1'b0, 12'd1, 16'h0001);
        handshake();
        chk("bp_err", 32'(err_cnt), 32'd2);

        // Same as f2 with idle gaps between beats
        send(16'h0001, 1'b0);
        repeat ($urandom_range(1, 3)) @(posedge clk);
        send(16'h0000, 1'b0);
        repeat ($urandom_range(1, 3)) @(posedge clk);
        send(16'h6801, 1'b1);
        check_res("gap", 1'b1, 1'b0, 12'd2, 16'h6801);
        handshake();

        // Reset mid-frame after three payload beats
        send(16'h0001, 1'b0); send(16'h0000, 1'b0); send(16'h0000, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mrst_valid", 32'(res_valid), 32'd0);
        chk("mrst_beats", 32'(res_beats), 32'd0);
        chk("mrst_crc", 32'(res_crc), 32'h0000);
        chk("mrst_err", 32'(err_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_in_ready", 32'(in_ready), 32'd1);
        send(16'h0001, 1'b0); send(16'h0001, 1'b1);
        check_res("post_rst", 1'b1, 1'b0, 12'd1, 16'h0001);
        handshake();

        // Five zero payload beats: narrow counter saturates, CRC still matches
        for (int i = 0; i < 5; i++) send(16'h0000, 1'b0);
        send(16'h0000, 1'b1);
        check_res("sat_wide", 1'b1, 1'b0, 12'd5, 16'h0000);
        chk("sat_small_valid", 32'(s_res_valid), 32'd1);
        chk("sat_small_beats", 32'(s_res_beats), 32'd3);
        chk("sat_small_ok", 32'(s_res_ok), 32'd1);
        handshake();
        chk("sat_err", 32'(err_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
